// File: rtl/muon_pkg.sv
// Shared types and constants for the muon decay sequencer.
`timescale 1ns/1ps
package muon_pkg;

   localparam int TIME_WIDTH_DEF = 16;
   localparam int TIMEOUT_W      = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WINDOW,
      ST_HOLD,
      ST_DEAD
   } state_t;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// A rise on async_in produces a one-cycle edge_out three cycles later.
`timescale 1ns/1ps
module pulse_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic edge_out
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic edge_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
         edge_q <= sync_q & ~prev_q;
      end
   end

   assign edge_out = edge_q;

endmodule

// File: rtl/muon_decay_sequencer.sv
// Measures the stop-to-decay interval of muon pulses, drives the external
// countdown timer and presents each measurement on a valid/ready handshake.
`timescale 1ns/1ps
module muon_decay_sequencer
   import muon_pkg::*;
#(
   parameter int TIME_WIDTH      = TIME_WIDTH_DEF,
   parameter int MIN_INTERVAL    = 4,
   parameter int DEADTIME_CYCLES = 200
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pulse_in,
   input  logic                  timer_done,
   output logic                  timer_start,
   output logic                  timer_reset,
   output logic                  event_valid,
   input  logic                  event_ready,
   output logic [TIME_WIDTH-1:0] event_time,
   output logic [TIMEOUT_W-1:0]  timeout_count
);

   localparam int DW = $clog2(DEADTIME_CYCLES + 1);
   localparam logic [TIME_WIDTH-1:0] MIN_T     = TIME_WIDTH'(MIN_INTERVAL);
   localparam logic [DW-1:0]         DEAD_LAST = DW'(DEADTIME_CYCLES - 1);

   logic                  pulse_edge;
   state_t                state_q;
   logic [TIME_WIDTH-1:0] cnt_q;
   logic [TIME_WIDTH-1:0] cnt_d;
   logic [DW-1:0]         dead_q;
   logic [TIMEOUT_W-1:0]  timeout_q;
   logic [TIMEOUT_W-1:0]  timeout_d;
   logic [TIME_WIDTH-1:0] event_time_q;
   logic                  event_valid_q;
   logic                  timer_start_q;
   logic                  timer_reset_q;
   logic                  decay_hit;

   pulse_sync_edge u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (pulse_in),
      .edge_out (pulse_edge)
   );

   // cnt_d is the elapsed cycle count since the start edge as of this cycle.
   assign cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   assign timeout_d = (timeout_q == '1) ? timeout_q : timeout_q + 1'b1;
   assign decay_hit = pulse_edge && (cnt_d >= MIN_T);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         dead_q        <= '0;
         timeout_q     <= '0;
         event_time_q  <= '0;
         event_valid_q <= 1'b0;
         timer_start_q <= 1'b0;
         timer_reset_q <= 1'b0;
      end else begin
         timer_start_q <= 1'b0;
         timer_reset_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pulse_edge) begin
                  timer_start_q <= 1'b1;
                  cnt_q         <= '0;
                  state_q       <= ST_WINDOW;
               end
            end
            ST_WINDOW: begin
               cnt_q <= cnt_d;
               // A decay wins over a simultaneous window expiry.
               if (decay_hit) begin
                  event_time_q  <= cnt_d;
                  event_valid_q <= 1'b1;
                  timer_reset_q <= 1'b1;
                  state_q       <= ST_HOLD;
               end else if (timer_done) begin
                  timeout_q <= timeout_d;
                  dead_q    <= '0;
                  state_q   <= ST_DEAD;
               end
            end
            ST_HOLD: begin
               if (event_valid_q && event_ready) begin
                  event_valid_q <= 1'b0;
                  dead_q        <= '0;
                  state_q       <= ST_DEAD;
               end
            end
            ST_DEAD: begin
               if (dead_q == DEAD_LAST) begin
                  state_q <= ST_IDLE;
               end else begin
                  dead_q <= dead_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign timer_start   = timer_start_q;
   assign timer_reset   = timer_reset_q;
   assign event_valid   = event_valid_q;
   assign event_time    = event_time_q;
   assign timeout_count = timeout_q;

endmodule

// File: tb/tb_muon_decay_sequencer.sv
// Directed self-checking bench for muon_decay_sequencer.
`timescale 1ns/1ps
module tb_muon_decay_sequencer;
   import muon_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        pulse_in = 1'b0;
   logic        timer_done = 1'b0;
   logic        event_ready = 1'b1;
   logic        timer_start;
   logic        timer_reset;
   logic        event_valid;
   logic [15:0] event_time;
   logic [15:0] timeout_count;

   int n_checks = 0;
   int n_fail   = 0;
   int ts_cnt = 0, tr_cnt = 0, ev_cyc = 0, hs_cnt = 0, both_cnt = 0;
   logic [15:0] last_time = '0;
   int ts0, tr0, hs0, ev0;

   muon_decay_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .pulse_in      (pulse_in),
      .timer_done    (timer_done),
      .timer_start   (timer_start),
      .timer_reset   (timer_reset),
      .event_valid   (event_valid),
      .event_ready   (event_ready),
      .event_time    (event_time),
      .timeout_count (timeout_count)
   );

   always #5 clk = ~clk;

   // Passive monitor of output pulses and handshakes.
   always @(posedge clk) begin
      if (timer_start) ts_cnt++;
      if (timer_reset) tr_cnt++;
      if (event_valid) ev_cyc++;
      if (timer_start && timer_reset) both_cnt++;
      if (event_valid && event_ready) begin
         hs_cnt++;
         last_time = event_time;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse();
      pulse_in = 1'b1;
      @(negedge clk);
      pulse_in = 1'b0;
   endtask

   task automatic snap();
      ts0 = ts_cnt;
      tr0 = tr_cnt;
      hs0 = hs_cnt;
      ev0 = ev_cyc;
   endtask

   initial begin
      // Reset state
      cycles(2);
      check("rst_timer_start", 32'(timer_start), 32'd0);
      check("rst_timer_reset", 32'(timer_reset), 32'd0);
      check("rst_event_valid", 32'(event_valid), 32'd0);
      check("rst_event_time", 32'(event_time), 32'd0);
      check("rst_timeout", 32'(timeout_count), 32'd0);
      check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      reset = 1'b1;
      cycles(3);

      // Two pulses 100 cycles apart
      snap();
      pulse();
      cycles(99);
      pulse();
      cycles(10);
      check("basic_start_pulses", 32'(ts_cnt - ts0), 32'd1);
      check("basic_reset_pulses", 32'(tr_cnt - tr0), 32'd1);
      check("basic_valid_cycles", 32'(ev_cyc - ev0), 32'd1);
      check("basic_event_time", 32'(last_time), 32'd100);
      cycles(205);
      check("basic_back_idle", 32'(dut.state_q), 32'(ST_IDLE));

      // Interval of 3 is noise, the later pulse at 10 is the decay
      snap();
      pulse();
      cycles(2);
      pulse();
      cycles(6);
      pulse();
      cycles(10);
      check("min3_event_time", 32'(last_time), 32'd10);
      check("min3_handshakes", 32'(hs_cnt - hs0), 32'd1);
      check("min3_start_pulses", 32'(ts_cnt - ts0), 32'd1);
      cycles(205);

      // Interval exactly MIN_INTERVAL qualifies
      snap();
      pulse();
      cycles(3);
      pulse();
      cycles(10);
      check("min4_event_time", 32'(last_time), 32'd4);
      check("min4_handshakes", 32'(hs_cnt - hs0), 32'd1);
      cycles(205);

      // After-pulse at 2 cycles ignored, decay at 50
      snap();
      pulse();
      cycles(1);
      pulse();
      cycles(47);
      pulse();
      cycles(10);
      check("afterpulse_event_time", 32'(last_time), 32'd50);
      check("afterpulse_handshakes", 32'(hs_cnt - hs0), 32'd1);
      check("afterpulse_resets", 32'(tr_cnt - tr0), 32'd1);
      cycles(205);

      // Window timeout
      snap();
      check("to_before", 32'(timeout_count), 32'd0);
      pulse();
      cycles(4999);
      timer_done = 1'b1;
      @(negedge clk);
      timer_done = 1'b0;
      check("to_count", 32'(timeout_count), 32'd1);
      check("to_state_dead", 32'(dut.state_q), 32'(ST_DEAD));
      check("to_no_valid", 32'(ev_cyc - ev0), 32'd0);
      cycles(199);
      check("to_dead_199", 32'(dut.state_q), 32'(ST_DEAD));
      cycles(1);
      check("to_idle_200", 32'(dut.state_q), 32'(ST_IDLE));
      cycles(5);

      // Stalled consumer with extra pulses and a timer_done during HOLD
      event_ready = 1'b0;
      snap();
      pulse();
      cycles(59);
      pulse();
      cycles(6);
      check("stall_valid_early", 32'(event_valid), 32'd1);
      check("stall_time_early", 32'(event_time), 32'd60);
      for (int i = 0; i < 30; i++) begin
         if (i % 6 == 0) begin
            pulse();
         end else if (i == 15) begin
            timer_done = 1'b1;
            cycles(1);
            timer_done = 1'b0;
         end else begin
            cycles(1);
         end
      end
      check("stall_valid_late", 32'(event_valid), 32'd1);
      check("stall_time_late", 32'(event_time), 32'd60);
      check("stall_no_handshake", 32'(hs_cnt - hs0), 32'd0);
      check("stall_timeout_kept", 32'(timeout_count), 32'd1);
      event_ready = 1'b1;
      cycles(1);
      event_ready = 1'b0;
      check("stall_valid_drop", 32'(event_valid), 32'd0);
      check("stall_handshakes", 32'(hs_cnt - hs0), 32'd1);
      check("stall_hs_time", 32'(last_time), 32'd60);
      cycles(10);
      pulse();
      cycles(90);
      pulse();
      cycles(80);
      pulse();
      cycles(30);
      check("stall_no_restart", 32'(ts_cnt - ts0), 32'd1);
      check("stall_idle", 32'(dut.state_q), 32'(ST_IDLE));
      event_ready = 1'b1;

      // Qualifying edge coincident with timer_done
      snap();
      pulse();
      cycles(19);
      pulse();
      cycles(2);
      timer_done = 1'b1;
      cycles(1);
      timer_done = 1'b0;
      cycles(5);
      check("coinc_timeout", 32'(timeout_count), 32'd1);
      check("coinc_handshakes", 32'(hs_cnt - hs0), 32'd1);
      check("coinc_event_time", 32'(last_time), 32'd20);
      check("coinc_resets", 32'(tr_cnt - tr0), 32'd1);
      cycles(205);

      // Reset mid-window
      pulse();
      cycles(2500);
      snap();
      reset = 1'b0;
      #1;
      check("mid_rst_start", 32'(timer_start), 32'd0);
      check("mid_rst_treset", 32'(timer_reset), 32'd0);
      check("mid_rst_valid", 32'(event_valid), 32'd0);
      check("mid_rst_time", 32'(event_time), 32'd0);
      check("mid_rst_timeout", 32'(timeout_count), 32'd0);
      check("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      cycles(2);
      check("mid_rst_no_treset", 32'(tr_cnt - tr0), 32'd0);
      reset = 1'b1;
      cycles(3);
      snap();
      pulse();
      cycles(29);
      pulse();
      cycles(10);
      check("post_rst_event_time", 32'(last_time), 32'd30);
      check("post_rst_handshakes", 32'(hs_cnt - hs0), 32'd1);
      check("post_rst_starts", 32'(ts_cnt - ts0), 32'd1);
      check("never_start_and_reset", 32'(both_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muon_decay_sequencer.md
MUON_DECAY_SEQUENCER -- requirements
Module: muon_decay_sequencer

Interface
REQ-001 Parameter TIME_WIDTH, 16, width of the decay interval counter and event_time.
REQ-002 Parameter MIN_INTERVAL, 4, minimum cycles between stop and decay pulses; closer pulses are after-pulse noise and are ignored.
REQ-003 Parameter DEADTIME_CYCLES, 200, cycles the block ignores pulses after each event or timeout.
REQ-004 clk  input  1  system clock, 100 MHz, all logic on the rising edge.
REQ-005 reset  input  1  reset, asynchronous and active-low.
REQ-006 pulse_in  input  1  discriminator output, asynchronous to clk, active-high.
REQ-007 timer_done  input  1  window-expired flag from the downstream countdown_timer.
REQ-008 timer_start  output  1  one-cycle pulse that starts the countdown_timer window.
REQ-009 timer_reset  output  1  one-cycle pulse that aborts the countdown_timer when a decay is captured.
REQ-010 event_valid  output  1  a decay measurement is presented on event_time.
REQ-011 event_ready  input  1  consumer accepts the measurement.
REQ-012 event_time  output  TIME_WIDTH  stop-to-decay interval in clk cycles.
REQ-013 timeout_count  output  16  number of windows that expired without a decay.

Function
REQ-014 pulse_in SHALL pass a two-flop synchroniser, then a rising-edge detector; an edge is one cycle wide, and asserts 3 cycles after pulse_in rises.
REQ-015 The FSM SHALL have states IDLE, WINDOW, HOLD and DEAD.
REQ-016 IDLE: an edge SHALL drive timer_start high for that cycle, clear the interval counter to 0 and enter WINDOW.
REQ-017 WINDOW: the counter SHALL increment by 1 per cycle and saturate at all-ones; it SHALL never wrap.
REQ-018 WINDOW: an edge with counter >= MIN_INTERVAL SHALL latch the counter into event_time, pulse timer_reset for one cycle and enter HOLD.
REQ-019 WINDOW: an edge with counter < MIN_INTERVAL SHALL be ignored, and the counter SHALL continue.
REQ-020 WINDOW: timer_done with no qualifying edge SHALL increment timeout_count, saturating at 0xFFFF, and enter DEAD.
REQ-021 A qualifying edge and timer_done in the same cycle SHALL be handled as a decay (REQ-018), and timeout_count SHALL stay unchanged.
REQ-022 HOLD: event_valid SHALL be high and event_time stable until the cycle where event_valid and event_ready are both high; the FSM SHALL then enter DEAD with event_valid low the next cycle.
REQ-023 HOLD: edges and timer_done SHALL be ignored; a stalled consumer SHALL NOT lose or overwrite the held event.
REQ-024 DEAD: the FSM SHALL ignore edges for exactly DEADTIME_CYCLES cycles, then enter IDLE.
REQ-025 timer_start and timer_reset SHALL never be high in the same cycle.
REQ-026 event_time value SHALL equal the cycle difference between the start edge and the decay edge.

Reset
REQ-027 While reset is low: state SHALL be IDLE; timer_start, timer_reset and event_valid SHALL be 0; event_time, timeout_count, the counters and the synchroniser flops SHALL be 0.
REQ-028 Reset asserted mid-WINDOW or mid-HOLD SHALL drop the pending event with no timer_reset pulse; the countdown_timer is reset by the same system reset.
REQ-029 After reset deasserts, the first edge accepted SHALL be no earlier than the 3rd rising clk edge.

Structure
REQ-030 A shared package muon_pkg SHALL hold the FSM state enum, the TIME_WIDTH default and the timeout_count width constant.
REQ-031 Synchroniser and edge detection SHALL be one sub-module, pulse_sync_edge (ports clk, reset, async_in, edge_out).

Verification
REQ-032 Pulses 1000 ns apart, event_ready held high -> timer_start once, event_valid for one cycle, event_time = 100, timer_reset once.
REQ-033 Single pulse, timer_done driven 5000 cycles later -> timeout_count 0 -> 1, event_valid never asserts, FSM in IDLE after 200 dead cycles.
REQ-034 Second pulse 20 ns after the first (2 cycles), third pulse 500 ns after the first -> first decay ignored, event_time = 50.
REQ-035 Decay captured with event_ready low for 30 cycles, extra pulses during the stall -> event_time unchanged, one handshake, no new timer_start until DEAD elapses.
REQ-036 Qualifying edge coincident with timer_done -> decay reported, timeout_count unchanged.
REQ-037 reset pulsed low mid-WINDOW (counter = 2500) -> all outputs 0 immediately, next pulse starts a fresh window with event_time measured from the new start.
